// File: rtl/central_pkg.sv
// Shared definitions for the central CPU debug blocks: default memory
// geometry, the program-area boundary and the dump engine state encoding.
// The CSUM state exists only when MEM_DUMP_CHECKSUM_EN is defined.
package central_pkg;

    localparam int INSTR_SIZE   = 12;
    localparam int ADDR_SIZE    = 5;
    localparam int PROGRAM_SIZE = 16;

`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HALT, READ, WAIT, SEND, CSUM, DONE
    } dump_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HALT, READ, WAIT, SEND, DONE
    } dump_state_t;
`endif

endpackage

// File: rtl/mem_dump_reader.sv
// Debug read-out engine for the central CPU memory. Freezes the CPU, reads a
// contiguous (wrapping) address range through the shared read port and
// streams each word with its address on a valid/ready interface.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends one checksum beat
// holding the sum (mod 2^INSTR_SIZE) of all data beats.
module mem_dump_reader #(
    parameter int INSTR_SIZE = central_pkg::INSTR_SIZE,
    parameter int ADDR_SIZE  = central_pkg::ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  first_addr,
    input  logic [ADDR_SIZE-1:0]  last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_halt,
    output logic                  mem_rd_en,
    output logic [ADDR_SIZE-1:0]  mem_rd_addr,
    input  logic [INSTR_SIZE-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [INSTR_SIZE-1:0] out_data,
    output logic                  out_last
);

    import central_pkg::*;

    dump_state_t           state_q, state_d;
    logic [ADDR_SIZE-1:0]  ptr_q;
    logic [ADDR_SIZE-1:0]  limit_q;
    logic                  at_limit;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [INSTR_SIZE-1:0] sum_q;
`endif

    assign at_limit = (ptr_q == limit_q);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; a beat is pending only in SEND/CSUM,
    // so no read can be issued while the stream is stalled.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        busy        = (state_q != IDLE);
        cpu_halt    = (state_q != IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = HALT;
            HALT: state_d = READ;
            READ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = ptr_q;
                state_d     = WAIT;
            end
            WAIT: state_d = SEND;
            SEND: begin
                out_valid = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                out_last  = 1'b0;
                if (out_ready) state_d = at_limit ? CSUM : READ;
`else
                out_last  = at_limit;
                if (out_ready) state_d = at_limit ? DONE : READ;
`endif
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: range latch, read pointer, beat capture and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            limit_q  <= '0;
            out_addr <= '0;
            out_data <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            if (state_q == IDLE && start) begin
                ptr_q   <= first_addr;
                limit_q <= last_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end
            if (state_q == WAIT) begin
                out_data <= mem_rd_data;
                out_addr <= ptr_q;
            end
            if (state_q == SEND && out_ready) begin
                if (!at_limit) ptr_q <= ptr_q + 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                sum_q <= sum_q + out_data;
                // out_addr already equals the limit for the checksum beat.
                if (at_limit) out_data <= sum_q + out_data;
`endif
            end
        end
    end

endmodule
